// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks data-memory words 0..N_WORDS-1 and streams them MSB-byte-first to the debug UART
//   i_clk, i_rst (async, active-low)    clock and reset
//   i_start                             start request, honoured only in IDLE
//   o_busy / o_done                     dump in progress / one-cycle completion pulse
//   o_mem_addr, o_mem_read_enable       synchronous read port of the data memory
//   i_mem_data                          read data, valid the cycle after the read
//   o_tx_data, o_tx_valid, i_tx_ready   byte stream towards the UART transmitter
module mem_dump_reader #(
    parameter int NB_BITS  = 32,
    parameter int NB_DEPTH = 10,
    parameter int N_WORDS  = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [NB_DEPTH-1:0]   o_mem_addr,
    output logic [NB_BITS/8-1:0]  o_mem_read_enable,
    input  logic [NB_BITS-1:0]    i_mem_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready
);

    localparam int NB_BYTES = NB_BITS / 8;
    localparam int NB_IDX   = NB_BYTES > 1 ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_DEPTH-1:0] LAST_WORD = NB_DEPTH'(N_WORDS - 1);
    localparam logic [NB_IDX-1:0]   LAST_BYTE = NB_IDX'(NB_BYTES - 1);

    if (NB_BITS % 8 != 0 || NB_BITS < 8) begin : g_bad_width
        $error("NB_BITS must be a positive multiple of 8");
    end
    if (N_WORDS < 1 || N_WORDS > 2 ** NB_DEPTH) begin : g_bad_words
        $error("N_WORDS must lie in 1..2**NB_DEPTH");
    end

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NB_DEPTH-1:0]   word_q, word_d;
    logic [NB_IDX-1:0]     idx_q, idx_d;
    logic [NB_BITS-1:0]    shift_q, shift_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    word_d  = '0;
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ:  state_d = LATCH;
            LATCH: begin
                shift_d = i_mem_data;
                state_d = SEND;
            end
            SEND: begin
                if (i_tx_ready) begin
                    shift_d = shift_q << 8;
                    idx_d   = (idx_q == LAST_BYTE) ? '0 : idx_q + 1'b1;
                    if (idx_q == LAST_BYTE) begin
                        // The counter stops on the last word; it never wraps back to 0.
                        state_d = (word_q == LAST_WORD) ? DONE : READ;
                        word_d  = (word_q == LAST_WORD) ? word_q : word_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address comes straight from the word counter, which only moves on entry to READ,
    // so it holds its last value in every other state.
    assign o_busy            = state_q != IDLE;
    assign o_done            = state_q == DONE;
    assign o_mem_addr        = word_q;
    assign o_mem_read_enable = {NB_BYTES{state_q == READ}};
    assign o_tx_valid        = state_q == SEND;
    assign o_tx_data         = o_tx_valid ? shift_q[NB_BITS-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb_mem_dump_reader: randomized self-checking bench for mem_dump_reader
module tb_mem_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic        start_a, ready_a, busy_a, done_a, valid_a;
    logic [9:0]  addr_a;
    logic [3:0]  re_a;
    logic [31:0] rd_a;
    logic [7:0]  tx_a;

    logic        start_b, ready_b, busy_b, done_b, valid_b;
    logic [9:0]  addr_b;
    logic [3:0]  re_b;
    logic [31:0] rd_b;
    logic [7:0]  tx_b;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    always @(posedge clk) if (re_a != 4'h0) rd_a <= mem_a[addr_a];
    always @(posedge clk) if (re_b != 4'h0) rd_b <= mem_b[addr_b];

    mem_dump_reader #(.NB_BITS(32), .NB_DEPTH(10), .N_WORDS(4)) u_a (
        .i_clk(clk), .i_rst(rst_n), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
        .o_mem_addr(addr_a), .o_mem_read_enable(re_a), .i_mem_data(rd_a),
        .o_tx_data(tx_a), .o_tx_valid(valid_a), .i_tx_ready(ready_a)
    );

    mem_dump_reader #(.NB_BITS(32), .NB_DEPTH(10), .N_WORDS(1024)) u_b (
        .i_clk(clk), .i_rst(rst_n), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
        .o_mem_addr(addr_b), .o_mem_read_enable(re_b), .i_mem_data(rd_b),
        .o_tx_data(tx_b), .o_tx_valid(valid_b), .i_tx_ready(ready_b)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] got_b[$];
    int         got_a[$];
    int done_cnt, done_at, first_valid, stalls, unstable, proto_bad;

    // Reference: byte b (0 = first sent) of a word is its b-th most significant byte.
    function automatic logic [7:0] model_byte(input logic [31:0] word, input int b);
        return 8'(word >> (8 * (3 - b)));
    endfunction

    // Drives one dump on instance A and records what it observes each cycle.
    // mode 0: ready always 1; 1: alternate 0/1 starting low during word 0; 2: random ready.
    task automatic run_a(input int mode, input bit extra, input int stop_after);
        int n;
        bit was_stall, tog, fin;
        logic [7:0] held;
        got_b.delete();
        got_a.delete();
        done_cnt = 0; done_at = -1; first_valid = -1; stalls = 0; unstable = 0; proto_bad = 0;
        was_stall = 0; tog = 0; held = 0; fin = 0;
        @(negedge clk); start_a = 1;
        @(negedge clk); start_a = 0;
        n = 1;
        while (!fin && n < 400) begin
            if (was_stall && (valid_a !== 1'b1 || tx_a !== held)) unstable++;
            if (re_a !== 4'h0) begin
                got_a.push_back(int'(addr_a));
                if (re_a !== 4'hF || valid_a) proto_bad++;
            end
            if (busy_a !== 1'b1) proto_bad++;
            if (valid_a && first_valid < 0) first_valid = n;
            if (done_a) begin done_cnt++; done_at = n; fin = 1; end
            if (mode == 1 && valid_a && got_b.size() < 4) begin ready_a = tog; tog = !tog; end
            else if (mode == 2) ready_a = 1'($urandom_range(0, 1));
            else ready_a = 1;
            start_a = extra && (n == 5 || done_a);
            if (valid_a && ready_a) begin
                got_b.push_back(tx_a);
                if (got_b.size() == stop_after) fin = 1;
            end
            if (valid_a && !ready_a) stalls++;
            was_stall = valid_a && !ready_a;
            held = tx_a;
            @(negedge clk); n++;
        end
        start_a = 0;
        ready_a = 1;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({busy_a, done_a, valid_a, re_a, tx_a, addr_a} !== 25'h0)
            begin errors++; $display("FAIL reset_async_a: got %h expected 0", {busy_a, done_a, valid_a, re_a, tx_a, addr_a}); end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_b, done_b, valid_b, re_b, tx_b, addr_b} !== 25'h0)
            begin errors++; $display("FAIL reset_hold_b: got %h expected 0", {busy_b, done_b, valid_b, re_b, tx_b, addr_b}); end
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy_a, done_a, valid_a, re_a, tx_a, addr_a} !== 25'h0)
                begin errors++; $display("FAIL idle_a cycle %0d: got %h expected 0", i, {busy_a, done_a, valid_a, re_a, tx_a, addr_a}); end
        end
    endtask

    task automatic test_basic();
        mem_a[0] = 32'h11223344; mem_a[1] = 32'h55667788;
        mem_a[2] = 32'h99AABBCC; mem_a[3] = 32'hDDEEFF00;
        run_a(0, 0, 0);
        checks++;
        if (got_b.size() != 16) begin errors++; $display("FAIL basic_count: got %0d expected 16", got_b.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= got_b.size() || got_b[i] !== model_byte(mem_a[i/4], i%4))
                begin errors++; $display("FAIL basic_byte %0d: got %h expected %h", i, (i < got_b.size()) ? got_b[i] : 8'hxx, model_byte(mem_a[i/4], i%4)); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_a.size() || got_a[i] != i)
                begin errors++; $display("FAIL basic_addr %0d: got %0d expected %0d", i, (i < got_a.size()) ? got_a[i] : -1, i); end
        end
        checks++;
        if (got_a.size() != 4) begin errors++; $display("FAIL basic_reads: got %0d expected 4", got_a.size()); end
        checks++;
        if (first_valid != 3) begin errors++; $display("FAIL basic_first_valid: got %0d expected 3", first_valid); end
        checks++;
        if (done_cnt != 1 || done_at != 25) begin errors++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 25", done_cnt, done_at); end
        checks++;
        if (proto_bad != 0) begin errors++; $display("FAIL basic_protocol: got %0d violations expected 0", proto_bad); end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL basic_after: got busy=%b done=%b expected 0 0", busy_a, done_a); end
    endtask

    task automatic test_backpressure();
        mem_a[0] = 32'hCAFEBABE;
        for (int i = 1; i < 4; i++) mem_a[i] = $urandom;
        run_a(1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= got_b.size() || got_b[i] !== model_byte(mem_a[i/4], i%4))
                begin errors++; $display("FAIL bp_byte %0d: got %h expected %h", i, (i < got_b.size()) ? got_b[i] : 8'hxx, model_byte(mem_a[i/4], i%4)); end
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable); end
        checks++;
        if (stalls != 4 || done_at != 29) begin errors++; $display("FAIL bp_latency: got stalls=%0d done_at=%0d expected 4 29", stalls, done_at); end
    endtask

    task automatic test_random_bp();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) mem_a[i] = $urandom;
            run_a(2, 0, 0);
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (i >= got_b.size() || got_b[i] !== model_byte(mem_a[i/4], i%4))
                    begin errors++; $display("FAIL rnd_byte r%0d %0d: got %h expected %h", r, i, (i < got_b.size()) ? got_b[i] : 8'hxx, model_byte(mem_a[i/4], i%4)); end
            end
            checks++;
            if (unstable != 0 || proto_bad != 0) begin errors++; $display("FAIL rnd_protocol r%0d: got unstable=%0d bad=%0d expected 0 0", r, unstable, proto_bad); end
            checks++;
            if (done_cnt != 1 || done_at != 25 + stalls) begin errors++; $display("FAIL rnd_latency r%0d: got done_at=%0d expected %0d", r, done_at, 25 + stalls); end
        end
    endtask

    task automatic test_start_busy();
        for (int i = 0; i < 4; i++) mem_a[i] = $urandom;
        run_a(0, 1, 0);
        checks++;
        if (done_cnt != 1 || done_at != 25 || got_a.size() != 4) begin errors++; $display("FAIL busy_ignore: got done_at=%0d reads=%0d expected 25 4", done_at, got_a.size()); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b0 || done_a !== 1'b0 || re_a !== 4'h0)
                begin errors++; $display("FAIL busy_no_restart cycle %0d: got busy=%b done=%b re=%h expected 0 0 0", i, busy_a, done_a, re_a); end
        end
        run_a(0, 0, 0);
        checks++;
        if (got_a.size() == 0 || got_a[0] != 0) begin errors++; $display("FAIL busy_restart_addr: got %0d expected 0", (got_a.size() > 0) ? got_a[0] : -1); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= got_b.size() || got_b[i] !== model_byte(mem_a[i/4], i%4))
                begin errors++; $display("FAIL busy_restart_byte %0d: got %h expected %h", i, (i < got_b.size()) ? got_b[i] : 8'hxx, model_byte(mem_a[i/4], i%4)); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) mem_a[i] = $urandom;
        run_a(0, 0, 10);
        rst_n = 0;
        #1;
        checks++;
        if ({busy_a, done_a, valid_a, re_a, tx_a, addr_a} !== 25'h0)
            begin errors++; $display("FAIL midreset_outputs: got %h expected 0", {busy_a, done_a, valid_a, re_a, tx_a, addr_a}); end
        checks++;
        if (done_cnt != 0 || got_b.size() != 10) begin errors++; $display("FAIL midreset_progress: got done=%0d bytes=%0d expected 0 10", done_cnt, got_b.size()); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL midreset_quiet: got busy=%b done=%b expected 0 0", busy_a, done_a); end
        end
        run_a(0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= got_b.size() || got_b[i] !== model_byte(mem_a[i/4], i%4))
                begin errors++; $display("FAIL midreset_byte %0d: got %h expected %h", i, (i < got_b.size()) ? got_b[i] : 8'hxx, model_byte(mem_a[i/4], i%4)); end
        end
        checks++;
        if (done_at != 25) begin errors++; $display("FAIL midreset_done: got %0d expected 25", done_at); end
    endtask

    task automatic test_full();
        int n, reads, last_addr, bad_order, bytes, byte_bad, fdone;
        for (int i = 0; i < 1024; i++) mem_b[i] = i;
        reads = 0; last_addr = -1; bad_order = 0; bytes = 0; byte_bad = 0; fdone = -1;
        ready_b = 1;
        @(negedge clk); start_b = 1;
        @(negedge clk); start_b = 0;
        n = 1;
        while (fdone < 0 && n < 7000) begin
            if (re_b !== 4'h0) begin
                if (int'(addr_b) != reads) bad_order++;
                last_addr = int'(addr_b);
                reads++;
            end
            if (valid_b && ready_b) begin
                if (tx_b !== model_byte(mem_b[bytes/4], bytes%4)) byte_bad++;
                bytes++;
            end
            if (done_b) fdone = n;
            @(negedge clk); n++;
        end
        checks++;
        if (reads != 1024 || bad_order != 0) begin errors++; $display("FAIL full_reads: got %0d reads %0d out of order expected 1024 0", reads, bad_order); end
        checks++;
        if (last_addr != 1023) begin errors++; $display("FAIL full_last_addr: got %0d expected 1023", last_addr); end
        checks++;
        if (bytes != 4096 || byte_bad != 0) begin errors++; $display("FAIL full_bytes: got %0d bytes %0d wrong expected 4096 0", bytes, byte_bad); end
        checks++;
        if (fdone != 6145) begin errors++; $display("FAIL full_done: got %0d expected 6145", fdone); end
        checks++;
        if (busy_b !== 1'b0 || addr_b !== 10'd1023) begin errors++; $display("FAIL full_after: got busy=%b addr=%0d expected 0 1023", busy_b, addr_b); end
    endtask

    initial begin
        start_a = 0; ready_a = 1; start_b = 0; ready_b = 1;
        test_reset();
        test_basic();
        test_backpressure();
        test_random_bp();
        test_start_busy();
        test_reset_mid();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
